// File: rtl/ikbd_pkg.sv
// Shared definitions for the Atari ST keyboard matrix: geometry, key code type
// and named matrix positions so the host-side scancode translator agrees with us.
package ikbd_pkg;

   localparam int NUM_COLS = 15;
   localparam int NUM_ROWS = 8;
   localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

   // Key position: col = code[6:3], row = code[2:0]
   typedef logic [6:0] key_code_t;

   typedef struct packed {
      logic      make;
      key_code_t code;
   } key_event_t;

   localparam key_code_t KEY_ESC    = 7'h01;
   localparam key_code_t KEY_TAB    = 7'h0F;
   localparam key_code_t KEY_CTRL   = 7'h1D;
   localparam key_code_t KEY_LSHIFT = 7'h2A;
   localparam key_code_t KEY_RSHIFT = 7'h36;
   localparam key_code_t KEY_ALT    = 7'h38;
   localparam key_code_t KEY_SPACE  = 7'h39;
   localparam key_code_t KEY_CAPS   = 7'h3A;

   function automatic logic code_valid(input key_code_t code);
      return code < 7'(NUM_KEYS);
   endfunction

endpackage

// File: rtl/ikbd_evt_fifo.sv
// Small first-word-fall-through event FIFO between the host event port and the
// key-array apply stage; flush drops every queued entry on the next edge.
module ikbd_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/ikbd_keymatrix.sv
// Atari ST keyboard switch matrix emulation: queued make/break events update a
// 120-key array that answers the 6301 column scan with active-low row senses.
module ikbd_keymatrix
   import ikbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MIN_HOLD   = 20000
) (
   input  logic                clk,
   input  logic                res_n,
   input  logic                ev_valid,
   output logic                ev_ready,
   input  key_code_t           ev_code,
   input  logic                ev_make,
   input  logic                all_up,
   input  logic [NUM_COLS-1:0] matrix_out,
   output logic [NUM_ROWS-1:0] matrix_in,
   output logic                busy
);

   localparam int            TW        = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
   localparam logic [TW-1:0] HOLD_LOAD = TW'(MIN_HOLD - 1);

   logic [NUM_KEYS-1:0] key_q, key_d;
   logic [TW-1:0]       hold_timer_q, hold_timer_d;
   key_code_t           hold_code_q, hold_code_d;
   logic [NUM_ROWS-1:0] matrix_in_q, matrix_in_d;

   logic                fifo_empty, fifo_full, push, pop, stall;
   logic [7:0]          head_bits;
   key_event_t          head;
   logic [NUM_ROWS-1:0] row_hit;

   assign ev_ready = res_n && !fifo_full && !all_up;
   assign push     = ev_valid && ev_ready;

   ikbd_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .res_n (res_n),
      .flush (all_up),
      .push  (push),
      .din   ({ev_make, ev_code}),
      .pop   (pop),
      .dout  (head_bits),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign head = key_event_t'(head_bits);

   // A break for the most recently made key waits until its hold time expires
   assign stall = !fifo_empty && !head.make && (head.code == hold_code_q) &&
                  (hold_timer_q != '0);
   assign pop   = !fifo_empty && !stall && !all_up;
   assign busy  = !fifo_empty || stall;

   always_comb begin
      key_d        = key_q;
      hold_code_d  = hold_code_q;
      hold_timer_d = (hold_timer_q != '0) ? hold_timer_q - 1'b1 : '0;
      if (all_up) begin
         key_d        = '0;
         hold_timer_d = '0;
      end else if (pop && code_valid(head.code)) begin
         if (head.make) begin
            key_d[head.code] = 1'b1;
            hold_timer_d     = HOLD_LOAD;
            hold_code_d      = head.code;
         end else begin
            key_d[head.code] = 1'b0;
         end
      end
   end

   // Selected columns OR together onto the shared row lines
   for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      logic [NUM_COLS-1:0] col_hit;
      for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
         assign col_hit[gc] = !matrix_out[gc] && key_q[gc*NUM_ROWS + gi];
      end
      assign row_hit[gi] = |col_hit;
   end

   assign matrix_in_d = ~row_hit;
   assign matrix_in   = matrix_in_q;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         key_q        <= '0;
         hold_timer_q <= '0;
         hold_code_q  <= '0;
         matrix_in_q  <= '1;
      end else begin
         key_q        <= key_d;
         hold_timer_q <= hold_timer_d;
         hold_code_q  <= hold_code_d;
         matrix_in_q  <= matrix_in_d;
      end
   end

endmodule

// File: tb/tb_ikbd_keymatrix.sv
// Self-checking bench for ikbd_keymatrix: directed vector table, hold-guard and
// FIFO corner sequences, then random events against a key-array reference.
module tb_ikbd_keymatrix;

   logic        clk = 1'b0;
   logic        res_n;
   logic        ev_valid;
   logic        ev_ready;
   logic [6:0]  ev_code;
   logic        ev_make;
   logic        all_up;
   logic [14:0] matrix_out;
   logic [7:0]  matrix_in;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit keys_m [120];

   typedef struct {
      logic [6:0]  code;
      logic        make;
      logic [14:0] mo;
      logic [7:0]  exp_mi;
   } vec_t;

   vec_t vecs [8];

   ikbd_keymatrix #(
      .FIFO_DEPTH (4),
      .MIN_HOLD   (20000)
   ) dut (
      .clk        (clk),
      .res_n      (res_n),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_code    (ev_code),
      .ev_make    (ev_make),
      .all_up     (all_up),
      .matrix_out (matrix_out),
      .matrix_in  (matrix_in),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("check %s: got %0h ok", name, act);
      end
   endtask

   task automatic send(input logic [6:0] code, input logic make, input int budget);
      bit done = 1'b0;
      ev_valid = 1'b1;
      ev_code  = code;
      ev_make  = make;
      for (int n = 0; n < budget && !done; n++) begin
         if (ev_ready) done = 1'b1;
         tick();
      end
      ev_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: event %02h make %0b not accepted in %0d cycles", code, make, budget);
      end else begin
         $display("event %02h make %0b accepted", code, make);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, budget);
      end
   endtask

   task automatic pulse_all_up();
      all_up = 1'b1;
      tick();
      all_up = 1'b0;
      tick();
      for (int k = 0; k < 120; k++) keys_m[k] = 1'b0;
   endtask

   // Reference: a row reads low when any selected column has that row's key down
   function automatic logic [7:0] model_mi(input logic [14:0] mo);
      logic [7:0] r = 8'hFF;
      for (int k = 0; k < 120; k++) begin
         if (keys_m[k] && !mo[k / 8]) r[k % 8] = 1'b0;
      end
      return r;
   endfunction

   initial begin
      int   cnt;
      bit   busy_ok, row5_ok;
      int   last_make;
      logic [6:0]  rc;
      logic        rm;
      logic [14:0] rmo;

      vecs[0] = '{7'h12, 1'b1, 15'h7FFB, 8'hFB};
      vecs[1] = '{7'h00, 1'b1, 15'h7FFA, 8'hFA};
      vecs[2] = '{7'h09, 1'b1, 15'h7FFD, 8'hFD};
      vecs[3] = '{7'h77, 1'b1, 15'h0000, 8'h78};
      vecs[4] = '{7'h12, 1'b0, 15'h0000, 8'h7C};
      vecs[5] = '{7'h7A, 1'b1, 15'h0000, 8'h7C};
      vecs[6] = '{7'h00, 1'b0, 15'h7FFE, 8'hFF};
      vecs[7] = '{7'h7F, 1'b0, 15'h3FFF, 8'h7F};

      res_n = 1'b0; ev_valid = 1'b0; ev_code = '0; ev_make = 1'b0;
      all_up = 1'b0; matrix_out = 15'h7FFE;
      for (int k = 0; k < 120; k++) keys_m[k] = 1'b0;

      repeat (3) tick();
      check("rst_matrix_in", matrix_in, 8'hFF);
      check("rst_ev_ready", ev_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      res_n = 1'b1;
      tick();
      check("idle_matrix_in", matrix_in, 8'hFF);
      check("idle_ev_ready", ev_ready, 1'b1);

      // Make-to-row latency and column deselect
      matrix_out = 15'h7FFB;
      send(7'h12, 1'b1, 10);
      check("lat_accept_edge", matrix_in, 8'hFF);
      tick();
      check("lat_apply_edge", matrix_in, 8'hFF);
      tick();
      check("lat_visible", matrix_in, 8'hFB);
      matrix_out = 15'h7FF7;
      tick();
      check("lat_col_deselect", matrix_in, 8'hFF);
      pulse_all_up();

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].code, vecs[i].make, 10);
         wait_idle(50);
         matrix_out = vecs[i].mo;
         tick();
         check($sformatf("vec%0d", i), matrix_in, vecs[i].exp_mi);
      end

      // all_up flushes queued events and clears the hold guard
      pulse_all_up();
      send(7'h00, 1'b1, 10);
      send(7'h09, 1'b1, 10);
      send(7'h77, 1'b1, 10);
      wait_idle(50);
      matrix_out = 15'h0000;
      tick();
      check("three_keys", matrix_in, 8'h7C);
      send(7'h77, 1'b0, 10);
      send(7'h05, 1'b1, 10);
      check("stalled_busy", busy, 1'b1);
      all_up = 1'b1;
      tick();
      check("all_up_ev_ready", ev_ready, 1'b0);
      all_up = 1'b0;
      check("all_up_busy", busy, 1'b0);
      tick();
      check("all_up_matrix_in", matrix_in, 8'hFF);
      repeat (3) tick();
      check("all_up_flushed", matrix_in, 8'hFF);
      send(7'h77, 1'b0, 10);
      tick();
      check("all_up_timer_clear", busy, 1'b0);

      // Minimum hold: make then immediate break, with a make queued behind
      pulse_all_up();
      matrix_out = 15'h7FFA;
      send(7'h12, 1'b1, 10);
      send(7'h12, 1'b0, 10);
      send(7'h05, 1'b1, 10);
      cnt = 0; busy_ok = 1'b1; row5_ok = 1'b1;
      while (matrix_in[2] == 1'b0 && cnt < 25000) begin
         cnt++;
         if (!busy) busy_ok = 1'b0;
         if (!matrix_in[5]) row5_ok = 1'b0;
         tick();
      end
      check("hold_cycles", cnt, 20000);
      check("hold_busy_throughout", busy_ok, 1'b1);
      check("hold_queued_waits", row5_ok, 1'b1);
      check("hold_done_busy", busy, 1'b0);
      tick();
      check("hold_queued_applied", matrix_in, 8'hDF);

      // Burst into a stalled FIFO
      pulse_all_up();
      matrix_out = 15'h7FEF;
      send(7'h20, 1'b1, 10);
      send(7'h20, 1'b0, 10);
      send(7'h21, 1'b1, 10);
      send(7'h22, 1'b1, 10);
      send(7'h23, 1'b1, 10);
      check("burst_full_ready", ev_ready, 1'b0);
      send(7'h24, 1'b1, 25000);
      check("burst_order", matrix_in, 8'hFF);
      wait_idle(50);
      tick();
      check("burst_final", matrix_in, 8'hE1);

      // Asynchronous reset in the middle of a stall
      pulse_all_up();
      matrix_out = 15'h7FFB;
      send(7'h12, 1'b1, 10);
      send(7'h12, 1'b0, 10);
      repeat (5) tick();
      check("pre_reset_busy", busy, 1'b1);
      check("pre_reset_matrix", matrix_in, 8'hFB);
      #3 res_n = 1'b0;
      #1;
      check("async_rst_matrix", matrix_in, 8'hFF);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_ready", ev_ready, 1'b0);
      @(posedge clk);
      #1 res_n = 1'b1;
      tick();
      for (int k = 0; k < 120; k++) keys_m[k] = 1'b0;

      // Random events against the reference key array; a break of the last
      // made key is turned into a make so the run never waits on the guard
      last_make = -1;
      for (int it = 0; it < 40; it++) begin
         int nev = int'($urandom_range(1, 3));
         for (int e = 0; e < nev; e++) begin
            rc = 7'($urandom_range(0, 127));
            rm = 1'($urandom % 2);
            if (!rm && int'(rc) == last_make) rm = 1'b1;
            send(rc, rm, 20);
            if (rc < 7'd120) begin
               keys_m[rc] = rm;
               if (rm) last_make = int'(rc);
            end
         end
         wait_idle(50);
         if ($urandom % 2 == 0) rmo = 15'($urandom);
         else rmo = ~(15'(1) << $urandom_range(0, 14));
         matrix_out = rmo;
         tick();
         check($sformatf("rand%0d_mo%04h", it, rmo), matrix_in, model_mi(rmo));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
